// File: rtl/pa_cpu.sv
// Shared CPU-board definitions for the interrupt controller: default IRQ count,
// handshake FSM states and the fixed-priority pick helper.
package pa_cpu;

  localparam int NBR_IRQS = 8;
  localparam int MAX_IRQS = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKW
  } e_int_state;

  // Lowest set index wins (index 0 is highest priority); 0 when nothing is set.
  function automatic int lowest_set(input logic [MAX_IRQS-1:0] v);
    lowest_set = 0;
    for (int i = MAX_IRQS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Sequencer <-> interrupt controller handshake plus the z_bus register-load strobes.
// master = sequencer side, slave = interrupt controller.
interface interrupt_controller_if #(
  parameter int NBR_IRQS = pa_cpu::NBR_IRQS
);
  localparam int ID_W = $clog2(NBR_IRQS);

  logic [7:0]      z_bus;
  logic            ctrl_irq_masks_wrt;
  logic            ctrl_int_vector_wrt;
  logic            ctrl_int_ack;
  logic            ctrl_clear_all_ints;
  logic            int_pending;
  logic [7:0]      int_vector;
  logic [ID_W-1:0] int_id;

  modport master (
    output z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack, ctrl_clear_all_ints,
    input  int_pending, int_vector, int_id
  );

  modport slave (
    input  z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack, ctrl_clear_all_ints,
    output int_pending, int_vector, int_id
  );

endinterface

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the IRQ pins. Build option IRQ_SYNC_EN inserts a
// 2-flop synchronizer per line ahead of the edge detect (adds two cycles).
module irq_edge_detect #(
  parameter int NBR_IRQS = 8
) (
  input  logic                clk,
  input  logic                _rst,
  input  logic [NBR_IRQS-1:0] irq_in,
  output logic [NBR_IRQS-1:0] rise
);

  logic [NBR_IRQS-1:0] irq_s;
  logic [NBR_IRQS-1:0] irq_prev;

`ifdef IRQ_SYNC_EN
  logic [NBR_IRQS-1:0] sync_q1;
  logic [NBR_IRQS-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!_rst) irq_prev <= '0;
    else       irq_prev <= irq_s;
  end

  // A level held high produces a single rise, hence a single request.
  assign rise = irq_s & ~irq_prev;

endmodule

// File: rtl/interrupt_controller.sv
// IRQ source for the microcode sequencer: edge-latched requests, mask register,
// fixed-priority pick and the int_pending / ack handshake. Optional build macro: IRQ_SYNC_EN.
module interrupt_controller #(
  parameter int NBR_IRQS = pa_cpu::NBR_IRQS
) (
  input  logic                   clk,
  input  logic                   _rst,
  input  logic [NBR_IRQS-1:0]    irq_in,
  interrupt_controller_if.slave  bus,
  output logic [NBR_IRQS-1:0]    irq_masks,
  output logic [NBR_IRQS-1:0]    irq_status
);
  import pa_cpu::*;

  localparam int ID_W = $clog2(NBR_IRQS);

  logic [NBR_IRQS-1:0] rise;
  logic [NBR_IRQS-1:0] pending;
  logic [NBR_IRQS-1:0] active;
  logic [NBR_IRQS-1:0] pend_clr;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     int_id_q;
  logic [7:ID_W+1]     vector_hi;
  logic                int_pending_q;
  e_int_state          state;

  irq_edge_detect #(.NBR_IRQS(NBR_IRQS)) u_edge (
    .clk    (clk),
    ._rst   (_rst),
    .irq_in (irq_in),
    .rise   (rise)
  );

  // Only the vector-base bits above the id field ever reach int_vector.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      irq_masks <= '0;
      vector_hi <= '0;
    end else begin
      if (!bus.ctrl_irq_masks_wrt)  irq_masks <= bus.z_bus[NBR_IRQS-1:0];
      if (!bus.ctrl_int_vector_wrt) vector_hi <= bus.z_bus[7:ID_W+1];
    end
  end

  assign active = pending & irq_masks;
  assign sel    = ID_W'(lowest_set(MAX_IRQS'(active)));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pend_clr = '0;
    if (bus.ctrl_clear_all_ints)                          pend_clr      = '1;
    else if (state == REQ && bus.ctrl_int_ack && |active) pend_clr[sel] = 1'b1;
  end

  // A rise in the same cycle as a clear re-sets the bit.
  always_ff @(posedge clk) begin
    if (!_rst) pending <= '0;
    else       pending <= (pending & ~pend_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state         <= IDLE;
      int_pending_q <= 1'b0;
      int_id_q      <= '0;
    end else if (bus.ctrl_clear_all_ints) begin
      int_pending_q <= 1'b0;
      state         <= bus.ctrl_int_ack ? ACKW : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          int_pending_q <= |active;
          if (|active) state <= REQ;
        end
        REQ: begin
          if (!(|active)) begin
            int_pending_q <= 1'b0;
            state         <= IDLE;
          end else if (bus.ctrl_int_ack) begin
            int_id_q      <= sel;
            int_pending_q <= 1'b0;
            state         <= ACKW;
          end else begin
            int_pending_q <= 1'b1;
          end
        end
        ACKW: begin
          // A multi-cycle ack counts once: wait for it to drop.
          int_pending_q <= 1'b0;
          if (!bus.ctrl_int_ack) state <= IDLE;
        end
        default: begin
          int_pending_q <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.int_pending = int_pending_q;
  assign bus.int_id      = int_id_q;
  assign bus.int_vector  = {vector_hi, int_id_q, 1'b0};
  assign irq_status      = pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_interrupt_controller;

  localparam int NB   = 8;
  localparam int ID_W = $clog2(NB);
  localparam int VSTEP = 2 ** (ID_W + 1);
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_l;
  logic [NB-1:0] irq_in;
  logic [NB-1:0] irq_masks;
  logic [NB-1:0] irq_status;
  bit            cmp_en = 1'b0;

  int total = 0;
  int bad   = 0;

  interrupt_controller_if #(.NBR_IRQS(NB)) bus ();

  interrupt_controller #(.NBR_IRQS(NB)) dut (
    .clk        (clk),
    ._rst       (rst_l),
    .irq_in     (irq_in),
    .bus        (bus),
    .irq_masks  (irq_masks),
    .irq_status (irq_status)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend[NB];
  bit m_mask[NB];
  bit m_prev[NB];
  bit m_s1[NB];
  bit m_s2[NB];
  int m_vbase;
  int m_id;
  bit m_req;   // request line to the sequencer is up
  bit m_busy;  // an acknowledge was taken and the ack line has not dropped yet

  task automatic model_step();
    bit eff[NB];
    bit rise[NB];
    int sel;
    if (!rst_l) begin
      for (int i = 0; i < NB; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      m_vbase = 0; m_id = 0; m_req = 0; m_busy = 0;
      return;
    end
`ifdef IRQ_SYNC_EN
    for (int i = 0; i < NB; i++) begin
      eff[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = irq_in[i];
    end
`else
    for (int i = 0; i < NB; i++) eff[i] = irq_in[i];
`endif
    for (int i = 0; i < NB; i++) begin
      rise[i] = eff[i] && !m_prev[i];
      m_prev[i] = eff[i];
    end
    sel = -1;
    for (int i = NB - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) sel = i;

    if (bus.ctrl_clear_all_ints) begin
      for (int i = 0; i < NB; i++) m_pend[i] = 0;
      m_req = 0; m_busy = bus.ctrl_int_ack;
    end else if (m_busy) begin
      m_req = 0; m_busy = bus.ctrl_int_ack;
    end else if (m_req) begin
      if (sel < 0) m_req = 0;
      else if (bus.ctrl_int_ack) begin
        m_id = sel; m_pend[sel] = 0; m_req = 0; m_busy = 1;
      end
    end else begin
      m_req = (sel >= 0);
    end

    for (int i = 0; i < NB; i++) if (rise[i]) m_pend[i] = 1;
    if (!bus.ctrl_irq_masks_wrt) for (int i = 0; i < NB; i++) m_mask[i] = bus.z_bus[i];
    if (!bus.ctrl_int_vector_wrt) m_vbase = int'(bus.z_bus);
  endtask

  always @(posedge clk) model_step();

  function automatic logic [31:0] pack(input bit a[NB]);
    logic [31:0] r = 0;
    for (int i = 0; i < NB; i++) if (a[i]) r = r + (32'd1 << i);
    return r;
  endfunction

  // Single compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("int_pending", 32'(bus.int_pending), 32'(m_req));
      check("int_id",      32'(bus.int_id),      32'(m_id));
      check("int_vector",  32'(bus.int_vector),  32'((m_vbase / VSTEP) * VSTEP + m_id * 2));
      check("irq_masks",   32'(irq_masks),       pack(m_mask));
      check("irq_status",  32'(irq_status),      pack(m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_mask(input logic [7:0] v);
    bus.z_bus = v; bus.ctrl_irq_masks_wrt = 1'b0;
    tick();
    bus.ctrl_irq_masks_wrt = 1'b1;
  endtask

  task automatic wr_vec(input logic [7:0] v);
    bus.z_bus = v; bus.ctrl_int_vector_wrt = 1'b0;
    tick();
    bus.ctrl_int_vector_wrt = 1'b1;
  endtask

  task automatic ack_pulse();
    bus.ctrl_int_ack = 1'b1;
    tick();
    bus.ctrl_int_ack = 1'b0;
  endtask

  task automatic raise(input logic [NB-1:0] bits);
    irq_in = bits;
    tick();
    irq_in = '0;
    repeat (LAT - 1) tick();
  endtask

  initial begin
    rst_l = 1'b0; irq_in = '0;
    bus.z_bus = '0; bus.ctrl_irq_masks_wrt = 1'b1; bus.ctrl_int_vector_wrt = 1'b1;
    bus.ctrl_int_ack = 1'b0; bus.ctrl_clear_all_ints = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst_l = 1'b1;
    check("rst_pending", 32'(bus.int_pending), 0);
    check("rst_vector",  32'(bus.int_vector), 0);
    check("rst_masks",   32'(irq_masks), 0);
    check("rst_status",  32'(irq_status), 0);

    // Single request on line 5, latency then acknowledge.
    wr_mask(8'hFF);
    irq_in = 8'h20;
    tick();
    irq_in = '0;
    check("t1_lat_1", 32'(bus.int_pending), 0);
    for (int c = 2; c <= LAT; c++) begin
      tick();
      check("t1_lat_n", 32'(bus.int_pending), (c == LAT) ? 1 : 0);
    end
    check("t1_status", 32'(irq_status), 32'h20);
    ack_pulse();
    check("t1_id",      32'(bus.int_id), 5);
    check("t1_status2", 32'(irq_status), 0);
    check("t1_vector",  32'(bus.int_vector), 32'h0A);
    tick();

    // Two simultaneous requests are served in priority order.
    wr_vec(8'hA0);
    raise(8'h44);
    check("t2_pend", 32'(bus.int_pending), 1);
    ack_pulse();
    check("t2_vec1",   32'(bus.int_vector), 32'hA4);
    check("t2_id1",    32'(bus.int_id), 2);
    check("t2_status", 32'(irq_status), 32'h40);
    tick();
    tick();
    check("t2_pend2", 32'(bus.int_pending), 1);
    ack_pulse();
    check("t2_vec2", 32'(bus.int_vector), 32'hAC);
    tick();

    // Masked request is held, fires once enabled.
    wr_mask(8'h00);
    raise(8'h08);
    check("t3_nopend", 32'(bus.int_pending), 0);
    check("t3_status", 32'(irq_status), 32'h08);
    wr_mask(8'h08);
    check("t3_pend0", 32'(bus.int_pending), 0);
    tick();
    check("t3_pend1", 32'(bus.int_pending), 1);
    ack_pulse();
    tick();

    // Ack held four cycles clears exactly one request.
    wr_mask(8'hFF);
    raise(8'h05);
    check("t4_pend", 32'(bus.int_pending), 1);
    bus.ctrl_int_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_held_pend",   32'(bus.int_pending), 0);
      check("t4_held_status", 32'(irq_status), 32'h04);
    end
    bus.ctrl_int_ack = 1'b0;
    tick();
    check("t4_idle", 32'(bus.int_pending), 0);
    tick();
    check("t4_rereq", 32'(bus.int_pending), 1);
    ack_pulse();
    tick();

    // New rise coincides with clear-all: the new request survives.
    raise(8'h10);
    irq_in = 8'h02;
    repeat (LAT - 2) tick();
    bus.ctrl_clear_all_ints = 1'b1;
    tick();
    bus.ctrl_clear_all_ints = 1'b0;
    irq_in = '0;
    check("t5_status", 32'(irq_status), 32'h02);
    check("t5_pend0",  32'(bus.int_pending), 0);
    tick();
    check("t5_pend1", 32'(bus.int_pending), 1);
    ack_pulse();
    tick();

    // Reset while a request is outstanding.
    raise(8'h01);
    check("t6_pend", 32'(bus.int_pending), 1);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    check("t6_pending", 32'(bus.int_pending), 0);
    check("t6_vector",  32'(bus.int_vector), 0);
    check("t6_id",      32'(bus.int_id), 0);
    check("t6_masks",   32'(irq_masks), 0);
    check("t6_status",  32'(irq_status), 0);

    // Randomized traffic against the model.
    wr_mask(8'hFF);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (NB'($urandom) & NB'($urandom));
      if (bus.ctrl_int_ack) bus.ctrl_int_ack = ($urandom_range(0, 1) == 0);
      else                  bus.ctrl_int_ack = ($urandom_range(0, 3) == 0);
      bus.ctrl_clear_all_ints = ($urandom_range(0, 39) == 0);
      bus.z_bus               = 8'($urandom);
      bus.ctrl_irq_masks_wrt  = ($urandom_range(0, 29) != 0);
      bus.ctrl_int_vector_wrt = ($urandom_range(0, 49) != 0);
      rst_l                   = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_l = 1'b1; irq_in = '0;
    bus.ctrl_int_ack = 1'b0; bus.ctrl_clear_all_ints = 1'b0;
    bus.ctrl_irq_masks_wrt = 1'b1; bus.ctrl_int_vector_wrt = 1'b1;
    tick();
    tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
